// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and unified-memory bus of mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch and a data requester.
// Define MEM_ARBITER_RR_EN for round-robin on conflicts; otherwise data beats fetch.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              pick;
`ifdef MEM_ARBITER_RR_EN
    // prio_q high means data wins the next simultaneous request
    logic              prio_q, prio_d;
    assign pick = (bus.if_req && bus.d_req) ? prio_q : bus.d_req;
`else
    assign pick = bus.d_req;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_ARBITER_RR_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: if (bus.if_req || bus.d_req) begin
                state_d = ISSUE;
                owner_d = pick;
                we_d    = pick && bus.d_we;
                addr_d  = pick ? bus.d_addr : bus.if_addr;
                wdata_d = pick ? bus.d_wdata : '0;
`ifdef MEM_ARBITER_RR_EN
                prio_d  = !pick;
`endif
            end
            ISSUE: begin
                state_d = (MEM_LAT == 1) ? RESP : WAIT;
                cnt_d   = 3'(MEM_LAT - 1);
            end
            WAIT: begin
                state_d = (cnt_q == 3'd1) ? RESP : WAIT;
                cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered images of the state being entered
        if_gnt_d    = (state_d == ISSUE) && !owner_d;
        d_gnt_d     = (state_d == ISSUE) && owner_d;
        mem_en_d    = state_d == ISSUE;
        mem_we_d    = (state_d == ISSUE) && we_d;
        if_rvalid_d = (state_d == RESP) && !owner_d;
        d_rvalid_d  = (state_d == RESP) && owner_d;
        busy_d      = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            prio_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
`ifdef MEM_ARBITER_RR_EN
            prio_q      <= prio_d;
`endif
        end
    end
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign busy          = busy_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, cycles from mem_en cycle to mem_rdata valid, legal range 1..8.
REQ-002 SHALL have parameters ADDR_W, default 32, and DATA_W, default 32: address and data widths.
REQ-003 SHALL have port clk  input  1  the one clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports if_req  input  1, if_addr  input  ADDR_W: fetch read request and its address.
REQ-006 SHALL have ports if_gnt  output  1, if_rvalid  output  1, if_rdata  output  DATA_W: fetch grant, read-data strobe and read data.
REQ-007 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  ADDR_W, d_wdata  input  DATA_W: data-port request.
REQ-008 SHALL have ports d_gnt  output  1, d_rvalid  output  1, d_rdata  output  DATA_W: data-port grant, completion strobe and read data.
REQ-009 SHALL have ports mem_en, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W: single-port unified memory.
REQ-010 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT and RESP; all outputs except if_rdata and d_rdata SHALL be registered.
REQ-012 IDLE with any request sampled: choose an owner, latch its address, write enable and write data, and go to ISSUE; stay in IDLE otherwise.
REQ-013 ISSUE lasts one cycle with mem_en=1, owner gnt=1, and mem_we=d_we for a data owner or 0 for a fetch owner.
REQ-014 WAIT SHALL count MEM_LAT-1 cycles with a 3-bit down-counter; for MEM_LAT=1, ISSUE goes straight to RESP.
REQ-015 RESP lasts one cycle, MEM_LAT cycles after ISSUE, with owner rvalid=1; the next state is IDLE.
REQ-016 if_rdata and d_rdata SHALL be combinational copies of mem_rdata; they are meaningful only while the matching rvalid is high.
REQ-017 A data write completes with d_rvalid=1 in RESP, and d_rdata is don't-care.
REQ-018 A requester SHALL hold req and payload until its gnt; a req dropped before the IDLE sample is withdrawn, and no gnt is issued for it.
REQ-019 req changes during ISSUE, WAIT or RESP SHALL be ignored; a new arbitration occurs only in IDLE.
REQ-020 Simultaneous requests in IDLE: priority follows REQ-029.
REQ-021 At most one gnt and one rvalid SHALL be high in any cycle, and mem_en is high only in ISSUE.
REQ-022 Each transaction SHALL occupy exactly MEM_LAT+2 cycles (IDLE sample, ISSUE, WAIT, RESP), so the back-to-back issue spacing is MEM_LAT+2.

Reset
REQ-023 Asserting reset SHALL immediately force state IDLE, counter 0, latched payload 0 and round-robin pointer to data.
REQ-024 Asserting reset SHALL immediately drive if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we and busy to 0, and mem_addr and mem_wdata to 0.
REQ-025 Reset mid-transaction SHALL abort it with no rvalid; the requester must re-request.
REQ-026 The first arbitration SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MEM_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-028 With MEM_ARBITER_RR_EN defined, simultaneous requests are served round-robin by a 1-bit last-owner pointer; a single requester is served regardless of the pointer.
REQ-029 With MEM_ARBITER_RR_EN undefined, fixed priority applies with data over fetch, no pointer logic, and possible fetch starvation.

Verification
REQ-030 MEM_LAT=2, only if_req=1 with if_addr=0x10 at cycle 0 -> if_gnt and mem_en=1, mem_we=0 at cycle 1; if_rvalid=1 at cycle 3 with if_rdata=mem_rdata; busy low at cycle 4.
REQ-031 d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF for one cycle; d_rvalid one cycle pulse after MEM_LAT cycles.
REQ-032 if_req and d_req held high for 4 transactions, fixed priority -> 4 data grants and 0 fetch grants; with MEM_ARBITER_RR_EN -> order D,F,D,F.
REQ-033 Reset asserted during WAIT -> all outputs 0 immediately and no rvalid afterward; a new if_req after release is served normally.
REQ-034 MEM_LAT=1 and MEM_LAT=8 single reads -> rvalid exactly 1 and 8 cycles after the mem_en cycle; exactly one gnt and one rvalid per transaction.
REQ-035 if_req pulsed in a WAIT cycle only -> ignored, with no if_gnt.
